// File: rtl/alu_mdu_seq.sv
// Multi-cycle EX-stage ALU with iterative multiply/divide.
// Single-cycle ops finish in one cycle; MULT/DIV iterate one bit per cycle.
module alu_mdu_seq #(
  parameter int  WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             div_by_zero
);

  localparam int CW = SHW + 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mb;
  logic               is_div, neg_q, neg_r, dbz_pend;

  logic               accept, mdu_op, div_in, sgn_in, sa, sb, b_zero;
  logic [WIDTH-1:0]   res1, mag_a, mag_b;

  assign accept    = in_valid && (state == IDLE);
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  assign mdu_op = (funct == 4'b1011) || (funct == 4'b1100) ||
                  (funct == 4'b1101) || (funct == 4'b1110);
  assign div_in = (funct == 4'b1101) || (funct == 4'b1110);
  assign sgn_in = (funct == 4'b1011) || (funct == 4'b1101);
  assign sa     = sgn_in && a[WIDTH-1];
  assign sb     = sgn_in && b[WIDTH-1];
  assign mag_a  = sa ? -a : a;
  assign mag_b  = sb ? -b : b;
  assign b_zero = (b == '0);

  always_comb begin
    res1 = '0;
    unique case (funct)
      4'b0000: res1 = a + b;
      4'b0001: res1 = a - b;
      4'b0010: res1 = a & b;
      4'b0011: res1 = a | b;
      4'b0100: res1 = a ^ b;
      4'b0101: res1 = b << shamt;
      4'b0110: res1 = b >> shamt;
      4'b0111: res1 = $unsigned($signed(b) >>> shamt);
      4'b1000: res1 = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      4'b1001: res1 = {{(WIDTH-1){1'b0}}, a < b};
      4'b1010: res1 = ~(a | b);
      default: res1 = '0;
    endcase
  end

  // Shift-add multiply step: acc = {partial product, remaining multiplier}
  logic [WIDTH:0]     msum;
  logic [2*WIDTH-1:0] mstep;
  assign msum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mb};
  assign mstep = acc[0] ? {msum, acc[WIDTH-1:1]}
                        : {1'b0, acc[2*WIDTH-1:1]};

  // Restoring divide step: acc = {remainder, dividend/quotient}
  logic [WIDTH:0]     dr, ddiff;
  logic [2*WIDTH-1:0] dstep;
  assign dr    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign ddiff = dr - {1'b0, mb};
  assign dstep = ddiff[WIDTH]
               ? {dr[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
               : {ddiff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   q_fix, r_fix, lo_fix, hi_fix;
  assign prod  = neg_q ? -acc : acc;
  assign q_fix = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign r_fix = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  always_comb begin
    lo_fix = prod[WIDTH-1:0];
    hi_fix = prod[2*WIDTH-1:WIDTH];
    if (dbz_pend) begin
      lo_fix = '1;
      hi_fix = acc[WIDTH-1:0];
    end else if (is_div) begin
      lo_fix = q_fix;
      hi_fix = r_fix;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (in_valid) begin
        if (!mdu_op)               state_nx = DONE;
        else if (div_in && b_zero) state_nx = FIX;
        else                       state_nx = CALC;
      end
      CALC: if (cnt == CW'(1)) state_nx = FIX;
      FIX:  state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= '0;
      acc         <= '0;
      mb          <= '0;
      is_div      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dbz_pend    <= 1'b0;
      lo          <= '0;
      hi          <= '0;
      zero        <= 1'b1;
      div_by_zero <= 1'b0;
    end else begin
      if (accept && mdu_op) begin
        cnt      <= CW'(WIDTH);
        is_div   <= div_in;
        neg_q    <= sa ^ sb;
        neg_r    <= sa;
        dbz_pend <= div_in && b_zero;
        mb       <= mag_b;
        // divide-by-zero keeps the raw dividend for hi
        acc      <= {{WIDTH{1'b0}}, (div_in && b_zero) ? a : mag_a};
      end else if (accept) begin
        lo          <= res1;
        hi          <= '0;
        zero        <= (res1 == '0);
        div_by_zero <= 1'b0;
      end
      if (state == CALC) begin
        cnt <= cnt - CW'(1);
        acc <= is_div ? dstep : mstep;
      end
      if (state == FIX) begin
        lo          <= lo_fix;
        hi          <= hi_fix;
        zero        <= (lo_fix == '0);
        div_by_zero <= dbz_pend;
      end
    end
  end

endmodule
